adc_lane_aligner: RTL and testbench

Parametrised lane-alignment stage for demultiplexed ADC capture paths. It sits after the DDR/QDR capture and recapture stage and before the user/FIFO interface. It takes NUM_CH channels of DEMUX parallel samples per clock plus per-lane sync and out-of-range flags. It locates the ADC sync marker within the demux word, locks onto it, and rotates all channels so the sync sample lands on lane 0. It also adds a valid qualifier and a saturating out-of-range event counter, neither of which the fixed-width capture block provides.

---
 rtl/adc_lane_aligner.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_lane_aligner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_lane_aligner.sv
// rtl/adc_lane_aligner.sv - sync-marker lane alignment for demultiplexed ADC capture
//
// Finds the single-lane ADC sync marker inside the demux word, locks on it
// after LOCK_COUNT consistent events and rotates every channel so the sync
// sample lands on lane 0. Adds a valid qualifier and a saturating
// out-of-range event counter.
//
// Ports:
//   clk, reset      capture clock, synchronous active-high reset
//   din             NUM_CH x DEMUX samples, channel c lane l at (c*DEMUX+l)*SAMPLE_W
//   din_sync        per-lane sync flags
//   din_oor         per-lane out-of-range flags
//   align_en        1 = search/lock, 0 = bypass (offset 0)
//   oor_clear       clears oor_count (wins over increment)
//   dout            rotated samples, same packing as din
//   dout_sync       rotated sync flags
//   dout_oor        rotated out-of-range flags
//   dout_valid      dout qualifier
//   locked          aligner is locked
//   align_offset    rotation currently applied
//   align_lost      sticky lock-loss flag, cleared when alignment is disabled
//   oor_count       saturating count of valid output cycles with any dout_oor bit

module adc_lane_aligner #(
   parameter int SAMPLE_W   = 8,
   parameter int DEMUX      = 4,
   parameter int NUM_CH     = 2,
   parameter int LOCK_COUNT = 4,
   parameter int OOR_CNT_W  = 16,
   localparam int OFF_W     = $clog2(DEMUX)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CH*DEMUX*SAMPLE_W-1:0] din,
   input  logic [DEMUX-1:0]                 din_sync,
   input  logic [DEMUX-1:0]                 din_oor,
   input  logic                             align_en,
   input  logic                             oor_clear,
   output logic [NUM_CH*DEMUX*SAMPLE_W-1:0] dout,
   output logic [DEMUX-1:0]                 dout_sync,
   output logic [DEMUX-1:0]                 dout_oor,
   output logic                             dout_valid,
   output logic                             locked,
   output logic [OFF_W-1:0]                 align_offset,
   output logic                             align_lost,
   output logic [OOR_CNT_W-1:0]             oor_count
);

   localparam int DATA_W = NUM_CH*DEMUX*SAMPLE_W;
   localparam int CH_W   = DEMUX*SAMPLE_W;
   localparam int WIN_IW = $clog2(2*DEMUX);
   localparam int DAT_IW = $clog2(2*CH_W);
   localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
   localparam logic [OOR_CNT_W-1:0] OOR_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_CONFIRM, S_LOCKED} state_t;

   state_t            state;
   logic [7:0]        cnt;
   logic [OFF_W-1:0]  cand;
   logic [1:0]        flush_cnt;

   logic [DATA_W-1:0] d1_data, d2_data;
   logic [DEMUX-1:0]  d1_sync, d2_sync, d1_oor, d2_oor;

   logic [DATA_W-1:0] mux_data;
   logic [DEMUX-1:0]  mux_sync, mux_oor;
   logic [2*CH_W-1:0] ch_win;
   logic [2*DEMUX-1:0] sync_win, oor_win;
   logic [WIN_IW-1:0] pos;
   logic [DAT_IW-1:0] dbase;

   logic [OFF_W-1:0]  sync_lane;
   logic              sync_any, sync_one;

   // Two-deep pipeline: the rotation window spans the older word (d2) and the
   // newer word (d1), so a marker on lane k pulls lanes k.. from d2 and the
   // wrap-around lanes from d1.
   always_ff @(posedge clk) begin
      if (reset) begin
         d1_data <= '0;
         d2_data <= '0;
         d1_sync <= '0;
         d2_sync <= '0;
         d1_oor  <= '0;
         d2_oor  <= '0;
      end else begin
         d1_data <= din;
         d2_data <= d1_data;
         d1_sync <= din_sync;
         d2_sync <= d1_sync;
         d1_oor  <= din_oor;
         d2_oor  <= d1_oor;
      end
   end

   always_comb begin
      mux_data = '0;
      mux_sync = '0;
      mux_oor  = '0;
      ch_win   = '0;
      pos      = '0;
      dbase    = '0;
      sync_win = {d1_sync, d2_sync};
      oor_win  = {d1_oor, d2_oor};
      for (int c = 0; c < NUM_CH; c++) begin
         ch_win = {d1_data[c*CH_W +: CH_W], d2_data[c*CH_W +: CH_W]};
         for (int j = 0; j < DEMUX; j++) begin
            pos   = WIN_IW'(align_offset) + WIN_IW'(j);
            dbase = DAT_IW'(pos) * DAT_IW'(SAMPLE_W);
            mux_data[(c*DEMUX+j)*SAMPLE_W +: SAMPLE_W] = ch_win[dbase +: SAMPLE_W];
         end
      end
      for (int j = 0; j < DEMUX; j++) begin
         pos         = WIN_IW'(align_offset) + WIN_IW'(j);
         mux_sync[j] = sync_win[pos];
         mux_oor[j]  = oor_win[pos];
      end
   end

   always_comb begin
      sync_lane = '0;
      for (int l = 0; l < DEMUX; l++) begin
         if (din_sync[l]) sync_lane = OFF_W'(l);
      end
      sync_any = |din_sync;
      sync_one = $onehot(din_sync);
   end

   // Alignment FSM. Every change of align_offset restarts the 3-cycle flush
   // so words straddling the old and new rotation are never marked valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cand         <= '0;
         align_offset <= '0;
         flush_cnt    <= 2'd3;
         locked       <= 1'b0;
         align_lost   <= 1'b0;
      end else begin
         if (flush_cnt != 2'd0) flush_cnt <= flush_cnt - 2'd1;
         if (!align_en) begin
            state      <= S_IDLE;
            locked     <= 1'b0;
            align_lost <= 1'b0;
            cnt        <= '0;
            if (align_offset != '0) begin
               align_offset <= '0;
               flush_cnt    <= 2'd3;
            end
         end else begin
            case (state)
               S_IDLE: state <= S_SEARCH;
               S_SEARCH: begin
                  if (sync_one) begin
                     cand <= sync_lane;
                     cnt  <= 8'd1;
                     if (LOCK_COUNT == 1) begin
                        state  <= S_LOCKED;
                        locked <= 1'b1;
                        if (align_offset != sync_lane) begin
                           align_offset <= sync_lane;
                           flush_cnt    <= 2'd3;
                        end
                     end else begin
                        state <= S_CONFIRM;
                     end
                  end
               end
               S_CONFIRM: begin
                  if (sync_any) begin
                     if (sync_one && sync_lane == cand) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == LOCK_TGT) begin
                           state  <= S_LOCKED;
                           locked <= 1'b1;
                           if (align_offset != cand) begin
                              align_offset <= cand;
                              flush_cnt    <= 2'd3;
                           end
                        end
                     end else begin
                        state <= S_SEARCH;
                        cnt   <= '0;
                     end
                  end
               end
               S_LOCKED: begin
                  if (sync_any && !(sync_one && sync_lane == align_offset)) begin
                     state      <= S_SEARCH;
                     locked     <= 1'b0;
                     align_lost <= 1'b1;
                     cnt        <= '0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout       <= '0;
         dout_sync  <= '0;
         dout_oor   <= '0;
         dout_valid <= 1'b0;
         oor_count  <= '0;
      end else begin
         dout       <= mux_data;
         dout_sync  <= mux_sync;
         dout_oor   <= mux_oor;
         dout_valid <= (flush_cnt == 2'd0) && (state == S_LOCKED || !align_en);
         if (oor_clear) begin
            oor_count <= '0;
         end else if (dout_valid && (|dout_oor) && oor_count != OOR_MAX) begin
            oor_count <= oor_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_lane_aligner.sv
// tb/tb_adc_lane_aligner.sv - randomized bench for adc_lane_aligner against a cycle-history model

module tb_adc_lane_aligner;

   localparam int SW   = 8;
   localparam int DM   = 4;
   localparam int NC   = 2;
   localparam int LC   = 4;
   localparam int OW   = 4;
   localparam int DW   = NC*DM*SW;
   localparam int MAXE = 8192;
   localparam int OOR_MAX = (1 << OW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] din;
   logic [DM-1:0] din_sync, din_oor;
   logic          align_en, oor_clear;
   logic [DW-1:0] dout;
   logic [DM-1:0] dout_sync, dout_oor;
   logic          dout_valid, locked, align_lost;
   logic [1:0]    align_offset;
   logic [OW-1:0] oor_count;

   adc_lane_aligner #(
      .SAMPLE_W(SW), .DEMUX(DM), .NUM_CH(NC), .LOCK_COUNT(LC), .OOR_CNT_W(OW)
   ) dut (
      .clk(clk), .reset(reset), .din(din), .din_sync(din_sync), .din_oor(din_oor),
      .align_en(align_en), .oor_clear(oor_clear), .dout(dout), .dout_sync(dout_sync),
      .dout_oor(dout_oor), .dout_valid(dout_valid), .locked(locked),
      .align_offset(align_offset), .align_lost(align_lost), .oor_count(oor_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // input history, indexed by the clock edge that sampled it
   logic [DW-1:0] h_din  [0:MAXE];
   logic [DM-1:0] h_sync [0:MAXE];
   logic [DM-1:0] h_oor  [0:MAXE];
   int edge_n = 0;

   // model: mode 0 = off/bypass, 1 = hunting, 2 = locked
   int m_mode, m_off, m_cand, m_streak, m_last_chg;
   bit m_lost;
   logic [DW-1:0] e_dout;
   logic [DM-1:0] e_sync, e_oor;
   bit e_valid;
   int e_oor_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp_v, edge_n);
      end
   endtask

   task automatic model_edge();
      int n, p, k, ncnt;
      bit nv, onehot;
      logic [DW-1:0] d;
      logic [DM-1:0] s, o;
      edge_n++;
      n = edge_n;
      if (n >= MAXE) $fatal(1, "FAIL edge_budget: got %0d expected below %0d", n, MAXE);
      h_din[n]  = din;
      h_sync[n] = din_sync;
      h_oor[n]  = din_oor;
      if (reset) begin
         h_din[n] = '0; h_sync[n] = '0; h_oor[n] = '0;
         if (n > 0) begin h_din[n-1] = '0; h_sync[n-1] = '0; h_oor[n-1] = '0; end
         m_mode = 0; m_off = 0; m_cand = 0; m_streak = 0; m_lost = 0; m_last_chg = n;
         e_dout = '0; e_sync = '0; e_oor = '0; e_valid = 0; e_oor_cnt = 0;
         return;
      end
      ncnt = e_oor_cnt;
      if (oor_clear) ncnt = 0;
      else if (e_valid && e_oor != '0 && ncnt < OOR_MAX) ncnt++;
      nv = (n - m_last_chg >= 4) && (m_mode == 2 || !align_en);
      d = '0; s = '0; o = '0;
      for (int j = 0; j < DM; j++) begin
         p = m_off + j;
         for (int c = 0; c < NC; c++) begin
            if (p < DM) d[(c*DM+j)*SW +: SW] = h_din[n-2][(c*DM+p)*SW +: SW];
            else        d[(c*DM+j)*SW +: SW] = h_din[n-1][(c*DM+p-DM)*SW +: SW];
         end
         s[j] = (p < DM) ? h_sync[n-2][p] : h_sync[n-1][p-DM];
         o[j] = (p < DM) ? h_oor[n-2][p]  : h_oor[n-1][p-DM];
      end
      onehot = ($countones(din_sync) == 1);
      k = 0;
      for (int l = 0; l < DM; l++) if (din_sync[l]) k = l;
      if (!align_en) begin
         m_mode = 0; m_lost = 0; m_streak = 0;
         if (m_off != 0) begin m_off = 0; m_last_chg = n; end
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (din_sync != '0) begin
         if (m_mode == 2) begin
            if (!(onehot && k == m_off)) begin m_mode = 1; m_lost = 1; m_streak = 0; end
         end else begin
            if (m_streak == 0) begin
               if (onehot) begin m_cand = k; m_streak = 1; end
            end else if (onehot && k == m_cand) m_streak++;
            else m_streak = 0;
            if (m_streak == LC) begin
               m_mode = 2; m_streak = 0;
               if (m_off != m_cand) begin m_off = m_cand; m_last_chg = n; end
            end
         end
      end
      e_dout = d; e_sync = s; e_oor = o; e_valid = nv; e_oor_cnt = ncnt;
   endtask

   task automatic compare_all();
      check("dout", dout, e_dout);
      check("dout_sync", dout_sync, e_sync);
      check("dout_oor", dout_oor, e_oor);
      check("dout_valid", dout_valid, e_valid);
      check("locked", locked, m_mode == 2);
      check("align_offset", align_offset, m_off);
      check("align_lost", align_lost, m_lost);
      check("oor_count", oor_count, e_oor_cnt);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_ramp(input int t);
      din = {$urandom, $urandom};
      for (int l = 0; l < DM; l++) din[l*SW +: SW] = 8'((4*t + l) % 256);
   endtask

   task automatic event_gap(input logic [DM-1:0] ev, input int gap);
      din = {$urandom, $urandom};
      din_sync = ev;
      step();
      din_sync = '0;
      repeat (gap) begin din = {$urandom, $urandom}; step(); end
   endtask

   logic [DM-1:0] mb_seq [7];
   int fav;

   initial begin
      reset = 1'b1; align_en = 1'b0; oor_clear = 1'b0;
      din = '0; din_sync = '0; din_oor = '0;
      repeat (2) step();
      check("rst_locked", locked, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_offset", align_offset, 0);
      check("rst_oor", oor_count, 0);
      reset = 1'b0;

      // bypass
      for (int t = 0; t < 30; t++) begin
         set_ramp(t);
         din_sync = 4'($urandom);
         din_oor  = 4'($urandom);
         step();
      end
      check("byp_valid", dout_valid, 1);
      check("byp_offset", align_offset, 0);

      // lock at offset 2
      align_en = 1'b1; din_oor = '0;
      for (int t = 0; t < 60; t++) begin
         set_ramp(t);
         din_sync = (t % 8 == 0) ? 4'b0100 : 4'b0000;
         step();
      end
      check("lock2_locked", locked, 1);
      check("lock2_offset", align_offset, 2);
      check("lock2_valid", dout_valid, 1);

      // mismatch while locked, then relock at 1
      din_sync = 4'b0010; step();
      check("mm_locked", locked, 0);
      check("mm_lost", align_lost, 1);
      din_sync = '0; step();
      check("mm_valid", dout_valid, 0);
      for (int t = 0; t < 40; t++) begin
         set_ramp(t);
         din_sync = (t % 8 == 4) ? 4'b0010 : 4'b0000;
         step();
      end
      check("lock1_locked", locked, 1);
      check("lock1_offset", align_offset, 1);
      check("lock1_lost_sticky", align_lost, 1);

      // multi-bit event during confirm restarts the search
      mb_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0100, 4'b0100};
      foreach (mb_seq[i]) event_gap(mb_seq[i], 3);
      check("mb_confirm_unlocked", locked, 0);
      event_gap(4'b0100, 3);
      check("mb_relock", locked, 1);
      check("mb_relock_off", align_offset, 2);

      // disable clears align_lost; relock, then a multi-bit event while locked
      align_en = 1'b0;
      repeat (3) step();
      check("dis_lost", align_lost, 0);
      check("dis_offset", align_offset, 0);
      align_en = 1'b1;
      repeat (6) event_gap(4'b0100, 3);
      check("mbl_locked", locked, 1);
      din_sync = 4'b0101; step();
      check("mbl_lost", align_lost, 1);
      check("mbl_unlocked", locked, 0);
      din_sync = '0;

      // randomized traffic
      fav = 2;
      for (int t = 0; t < 1500; t++) begin
         int r;
         din = {$urandom, $urandom};
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 299) == 0) fav = $urandom_range(0, DM-1);
         if (r < 12)      din_sync = 4'(1 << fav);
         else if (r < 14) din_sync = 4'($urandom_range(1, 15));
         else             din_sync = '0;
         din_oor   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         oor_clear = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) align_en = ~align_en;
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0; oor_clear = 1'b0; din_sync = '0;

      // out-of-range counter saturation and clear priority
      align_en = 1'b0;
      oor_clear = 1'b1; step(); oor_clear = 1'b0;
      din_oor = 4'b0001;
      repeat (30) begin din = {$urandom, $urandom}; step(); end
      check("oor_sat", oor_count, 15);
      oor_clear = 1'b1; step(); oor_clear = 1'b0;
      check("oor_clear_wins", oor_count, 0);
      din_oor = '0;

      // reset while locked requires a full relock
      align_en = 1'b1;
      repeat (7) event_gap(4'b1000, 5);
      check("pre_rst_locked", locked, 1);
      check("pre_rst_offset", align_offset, 3);
      reset = 1'b1; step(); reset = 1'b0;
      check("mid_rst_locked", locked, 0);
      check("mid_rst_offset", align_offset, 0);
      check("mid_rst_dout", dout, 0);
      check("mid_rst_valid", dout_valid, 0);
      repeat (4) event_gap(4'b1000, 5);
      check("post_rst_partial", locked, 0);
      repeat (2) event_gap(4'b1000, 5);
      check("post_rst_locked", locked, 1);
      check("post_rst_offset", align_offset, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
